// File: rtl/seq_det_ctrl.sv
// Serial pattern-detection run controller: latches config on start, counts overlapping
// pattern hits on the qualified bit stream, and ends on target, timeout or abort.
module seq_det_ctrl #(
  parameter int SEQ_W = 8,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SEQ_W-1:0] cfg_seq,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timed_out
);

  localparam int BC_W = $clog2(SEQ_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SEARCH, S_FINISH, S_TMO
  } state_t;

  state_t           state, state_nxt;
  logic [SEQ_W-1:0] seq_sh, window, window_nxt;
  logic [CNT_W-1:0] target_sh;
  logic [TO_W-1:0]  timeout_sh, to_cnt;
  logic [BC_W-1:0]  bit_cnt;
  logic             accept, match, final_match, to_expire;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [BC_W-1:0] sat_inc_bits(input logic [BC_W-1:0] v);
    return (v == BC_W'(SEQ_W)) ? v : v + {{(BC_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    window_nxt  = {window[SEQ_W-2:0], ser_data};
    accept      = (state == S_IDLE) && start && !abort;
    // a match needs a full window of received bits including the current one
    match       = (state == S_SEARCH) && ser_valid &&
                  (bit_cnt >= BC_W'(SEQ_W - 1)) && (window_nxt == seq_sh);
    final_match = match && (target_sh != '0) &&
                  (match_cnt == target_sh - {{(CNT_W-1){1'b0}}, 1'b1});
    to_expire   = (state == S_SEARCH) && (timeout_sh != '0) &&
                  (to_cnt == timeout_sh - {{(TO_W-1){1'b0}}, 1'b1});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ARM;
      S_ARM:    state_nxt = abort ? S_IDLE : S_SEARCH;
      S_SEARCH: begin
        if (abort)            state_nxt = S_IDLE;
        else if (final_match) state_nxt = S_FINISH;
        else if (to_expire)   state_nxt = S_TMO;
      end
      S_FINISH: state_nxt = S_IDLE;
      S_TMO:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_ARM) || (state == S_SEARCH);
  assign done = (state == S_FINISH) || (state == S_TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_sh     <= '0;
      target_sh  <= '0;
      timeout_sh <= '0;
      window     <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      match_cnt  <= '0;
      timed_out  <= 1'b0;
      hit        <= 1'b0;
    end else begin
      hit <= match && !abort;
      if (accept) begin
        seq_sh     <= cfg_seq;
        target_sh  <= cfg_target;
        timeout_sh <= cfg_timeout;
        window     <= '0;
        bit_cnt    <= '0;
        to_cnt     <= '0;
        match_cnt  <= '0;
        timed_out  <= 1'b0;
      end
      if ((state == S_SEARCH) && !abort) begin
        to_cnt <= to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        if (ser_valid) begin
          window  <= window_nxt;
          bit_cnt <= sat_inc_bits(bit_cnt);
        end
        if (match) match_cnt <= sat_inc_cnt(match_cnt);
      end
      // an abort arriving in TMO leaves the previous status untouched
      if ((state == S_TMO) && !abort) timed_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed and randomized runs checked cycle by cycle against
// a bit-history reference model of the detection rules.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [7:0]  cfg_seq, cfg_target;
  logic [15:0] cfg_timeout;
  logic        ser_valid, ser_data;
  logic        busy, hit, done, timed_out;
  logic [7:0]  match_cnt;

  seq_det_ctrl #(.SEQ_W(8), .CNT_W(8), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_seq(cfg_seq), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
    .ser_valid(ser_valid), .ser_data(ser_data),
    .busy(busy), .hit(hit), .match_cnt(match_cnt), .done(done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // per-search-cycle stimulus and per-cycle {busy,hit,done,timed_out,match_cnt}
  bit          sv [0:399];
  bit          sd [0:399];
  logic [11:0] exp_v [0:399];
  logic [11:0] obs_v [0:399];
  int          ncyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_case(input logic [7:0] pat, input logic [7:0] tgt, input logic [15:0] tmo,
                          input int nsrch, input int abort_at, input bit spam);
    bit bq[$];
    int cnt;
    cnt  = 0;
    exp_v[0] = {4'b1000, 8'd0};
    exp_v[1] = {4'b1000, 8'd0};
    ncyc = 2;
    for (int j = 0; j < nsrch; j++) begin
      bit h, fin, tox, ok;
      if (j == abort_at) begin
        exp_v[ncyc] = {4'b0000, 8'(cnt)};
        ncyc++;
        break;
      end
      h = 1'b0;
      if (sv[j]) begin
        bq.push_back(sd[j]);
        if (bq.size() >= 8) begin
          ok = 1'b1;
          for (int i = 0; i < 8; i++)
            if (bq[bq.size() - 8 + i] != pat[7-i]) ok = 1'b0;
          h = ok;
        end
        if (h && cnt < 255) cnt++;
      end
      fin = h && (tgt != 0) && (cnt == int'(tgt));
      tox = !fin && (tmo != 0) && (j + 1 == int'(tmo));
      exp_v[ncyc] = {~(fin | tox), h, fin | tox, 1'b0, 8'(cnt)};
      ncyc++;
      if (fin | tox) begin
        exp_v[ncyc] = {3'b000, tox, 8'(cnt)};
        ncyc++;
        break;
      end
    end

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b1; abort = 1'b0;
        cfg_seq = pat; cfg_target = tgt; cfg_timeout = tmo;
        ser_valid = 1'($urandom); ser_data = 1'($urandom);
      end else begin
        start       = spam ? 1'($urandom) : 1'b0;
        cfg_seq     = 8'($urandom);
        cfg_target  = 8'($urandom);
        cfg_timeout = 16'($urandom);
        if (c >= 2) begin
          ser_valid = sv[c-2]; ser_data = sd[c-2]; abort = (c - 2 == abort_at);
        end else begin
          ser_valid = 1'b1; ser_data = 1'($urandom); abort = 1'b0;
        end
      end
      @(posedge clk); #1;
      obs_v[c] = {busy, hit, done, timed_out, match_cnt};
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; ser_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({busy, hit, done, timed_out, match_cnt} !== 12'h000) begin
      nerr++; $display("FAIL reset_hold: got %h want 000", {busy, hit, done, timed_out, match_cnt});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if ({busy, hit, done, timed_out, match_cnt} !== 12'h000) begin
      nerr++; $display("FAIL reset_release: got %h want 000", {busy, hit, done, timed_out, match_cnt});
    end
  endtask

  task automatic test_basic;
    for (int j = 0; j < 12; j++) begin sv[j] = 1'b1; sd[j] = (j % 4 == 0) || (j % 4 == 3); end
    run_case(8'b10011001, 8'd2, 16'd0, 12, -1, 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      nvec++;
      if (obs_v[c] !== exp_v[c]) begin
        nerr++; $display("FAIL basic cyc %0d: got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    nvec++;
    if (obs_v[13] !== 12'h602 || obs_v[14] !== 12'h002 || obs_v[9] !== 12'hc01) begin
      nerr++; $display("FAIL basic_const: got %h %h %h want c01 602 002", obs_v[9], obs_v[13], obs_v[14]);
    end
  endtask

  task automatic test_valid_gaps;
    for (int j = 0; j < 24; j++) begin
      sv[j] = (j % 2 == 0);
      sd[j] = sv[j] ? (((j / 2) % 4 == 0) || ((j / 2) % 4 == 3)) : 1'($urandom);
    end
    run_case(8'b10011001, 8'd2, 16'd0, 24, -1, 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      nvec++;
      if (obs_v[c] !== exp_v[c]) begin
        nerr++; $display("FAIL valid_gaps cyc %0d: got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_timeout;
    for (int j = 0; j < 40; j++) begin sv[j] = 1'b1; sd[j] = 1'b0; end
    run_case(8'b10011001, 8'd1, 16'd20, 40, -1, 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      nvec++;
      if (obs_v[c] !== exp_v[c]) begin
        nerr++; $display("FAIL timeout cyc %0d: got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    nvec++;
    if (ncyc != 23 || obs_v[21] !== 12'h200 || obs_v[22] !== 12'h100) begin
      nerr++; $display("FAIL timeout_const: got %h %h want 200 100", obs_v[21], obs_v[22]);
    end
  endtask

  task automatic test_match_vs_timeout;
    logic [7:0] pat;
    pat = 8'($urandom);
    for (int j = 0; j < 8; j++) begin sv[j] = 1'b1; sd[j] = pat[7-j]; end
    run_case(pat, 8'd1, 16'd8, 8, -1, 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      nvec++;
      if (obs_v[c] !== exp_v[c]) begin
        nerr++; $display("FAIL tie_final cyc %0d: got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    nvec++;
    if (obs_v[9] !== 12'h601 || obs_v[10] !== 12'h001) begin
      nerr++; $display("FAIL tie_const: got %h %h want 601 001", obs_v[9], obs_v[10]);
    end
    // non-final match on the timeout edge still pulses hit but ends by timeout
    for (int j = 0; j < 12; j++) begin sv[j] = 1'b1; sd[j] = 1'b1; end
    run_case(8'hff, 8'd5, 16'd9, 12, -1, 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      nvec++;
      if (obs_v[c] !== exp_v[c]) begin
        nerr++; $display("FAIL tie_nonfinal cyc %0d: got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_saturate;
    for (int j = 0; j < 300; j++) begin sv[j] = 1'b1; sd[j] = 1'b1; end
    run_case(8'hff, 8'd0, 16'd300, 300, -1, 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      nvec++;
      if (obs_v[c] !== exp_v[c]) begin
        nerr++; $display("FAIL saturate cyc %0d: got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] pat;
    pat = 8'b10110001;
    for (int j = 0; j < 20; j++) begin sv[j] = 1'b1; sd[j] = (j < 8) ? pat[7-j] : 1'b0; end
    run_case(pat, 8'd3, 16'd0, 20, 10, 1'b1);
    for (int c = 0; c < ncyc; c++) begin
      nvec++;
      if (obs_v[c] !== exp_v[c]) begin
        nerr++; $display("FAIL abort cyc %0d: got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    nvec++;
    if (obs_v[ncyc-1] !== 12'h001) begin
      nerr++; $display("FAIL abort_const: got %h want 001", obs_v[ncyc-1]);
    end
    @(negedge clk);
    start = 1'b1; abort = 1'b1; cfg_seq = pat; cfg_target = 8'd1; cfg_timeout = 16'd0;
    @(posedge clk); #1;
    nvec++;
    if ({busy, match_cnt} !== 9'h001) begin
      nerr++; $display("FAIL start_with_abort: got %h want 001", {busy, match_cnt});
    end
    @(negedge clk); start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    start = 1'b1; cfg_seq = 8'hff; cfg_target = 8'd0; cfg_timeout = 16'd0;
    repeat (12) begin
      @(negedge clk);
      start = 1'b0; ser_valid = 1'b1; ser_data = 1'b1;
    end
    @(posedge clk); #1;
    nvec++;
    if ({busy, match_cnt} !== 9'h104) begin
      nerr++; $display("FAIL pre_reset: got %h want 104", {busy, match_cnt});
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, hit, done, timed_out, match_cnt} !== 12'h000) begin
      nerr++; $display("FAIL async_reset: got %h want 000", {busy, hit, done, timed_out, match_cnt});
    end
    ser_valid = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if ({busy, hit, done, timed_out, match_cnt} !== 12'h000) begin
      nerr++; $display("FAIL post_reset: got %h want 000", {busy, hit, done, timed_out, match_cnt});
    end
  endtask

  task automatic test_random(input int runs);
    for (int r = 0; r < runs; r++) begin
      logic [7:0]  pat, tgt;
      logic [15:0] tmo;
      int k, ab;
      pat = 8'($urandom);
      k = 0;
      for (int j = 0; j < 350; j++) begin
        sv[j] = ($urandom % 4) != 0;
        if (sv[j]) begin
          sd[j] = ($urandom % 10 == 0) ? 1'($urandom) : pat[7 - (k % 8)];
          k++;
        end else sd[j] = 1'($urandom);
      end
      tgt = 8'($urandom_range(3, 0));
      tmo = ($urandom % 3 == 0) ? 16'd0 : 16'($urandom_range(200, 20));
      if (tmo == 0) ab = int'($urandom_range(300, 40));
      else          ab = ($urandom % 4 == 0) ? int'($urandom_range(150, 10)) : -1;
      run_case(pat, tgt, tmo, 350, ab, 1'b1);
      for (int c = 0; c < ncyc; c++) begin
        nvec++;
        if (obs_v[c] !== exp_v[c]) begin
          nerr++; $display("FAIL random run %0d cyc %0d: got %h want %h", r, c, obs_v[c], exp_v[c]);
        end
      end
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
    cfg_seq = '0; cfg_target = '0; cfg_timeout = '0;
    test_reset;
    test_basic;
    test_valid_gaps;
    test_timeout;
    test_match_vs_timeout;
    test_saturate;
    test_abort;
    test_async_reset;
    test_random(8);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
